sseg_scan: RTL and testbench
============================

SSEG_SCAN -- requirements
Module: sseg_scan

Interface
REQ-001 Parameter REFRESH_DIV, default 100000, clk cycles per digit slot (legal range >= 2).
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 data_in  input  16  new display value offered by producer.
REQ-005 hex_dec_in  input  1  new hex/decimal mode offered with data_in.
REQ-006 sign_in  input  1  new sign flag offered with data_in.
REQ-007 load_valid  input  1  producer offers data_in/hex_dec_in/sign_in this cycle.
REQ-008 load_ready  output  1  block can accept an offer this cycle.
REQ-009 data  output  16  registered display value to the seven-segment driver.
REQ-010 hex_dec  output  1  registered mode to the seven-segment driver.
REQ-011 sign  output  1  registered sign flag to the seven-segment driver.
REQ-012 digit_sel  output  2  registered active digit index to the seven-segment driver.
REQ-013 digit_tick  output  1  high for one cycle, in the last cycle of each digit slot.
REQ-014 frame_done  output  1  high for one cycle, in the last cycle of digit slot 3.

Function
REQ-015 The prescaler SHALL count 0..REFRESH_DIV-1 and wrap to 0; its width is ceil(log2(REFRESH_DIV)) bits.
REQ-016 digit_tick SHALL be high exactly when prescaler == REFRESH_DIV-1 (combinational decode of registered state).
REQ-017 On the edge ending a digit_tick cycle, digit_sel SHALL increment modulo 4 (3 -> 0); otherwise it holds.
REQ-018 frame_done SHALL equal digit_tick AND (digit_sel == 3).
REQ-019 A frame SHALL be 4*REFRESH_DIV cycles, digit_sel sequence 0,1,2,3,0,...
REQ-020 Internal state: shadow register (16+1+1 bits) and pending flag.
REQ-021 load_ready SHALL equal NOT pending.
REQ-022 An offer is accepted on an edge where load_valid AND load_ready; shadow <= {data_in, hex_dec_in, sign_in}, pending <= 1.
REQ-023 load_valid while load_ready is low SHALL be ignored; shadow and pending unchanged; no queuing.
REQ-024 On the edge ending a frame_done cycle with pending == 1 at the start of that cycle, data/hex_dec/sign SHALL load from shadow and pending SHALL clear.
REQ-025 data/hex_dec/sign SHALL change only per REQ-024, so a value never changes mid-frame (no tearing).
REQ-026 Offer accepted in a frame_done cycle with pending == 0: captured into shadow, NOT applied at that boundary; applied at the next frame_done.
REQ-027 Display update latency: visible in the cycle after the first frame_done that begins with pending == 1; worst case 4*REFRESH_DIV cycles after acceptance.
REQ-028 Prescaler and digit_sel SHALL run continuously, independent of handshake activity.

Reset
REQ-029 While reset is high at an edge: prescaler 0, digit_sel 0, data 16'h0000, hex_dec 0, sign 0, shadow 0, pending 0.
REQ-030 Consequently during and after reset: load_ready 1, digit_tick 0, frame_done 0 (REFRESH_DIV >= 2).
REQ-031 Reset mid-operation SHALL discard a pending value; the offer present on load_valid in a reset cycle is not accepted.
REQ-032 First cycle after reset release is cycle 0 of digit slot 0.

Verification (REFRESH_DIV = 4, cycle 0 = first cycle after reset release)
REQ-033 Free run, no loads -> digit_tick high in cycles 3,7,11,15; frame_done only in cycle 15; digit_sel 0,1,2,3 in cycles 0-3,4-7,8-11,12-15, then 0 in cycle 16; data stays 16'h0000.
REQ-034 load_valid in cycle 5 with data_in 16'h1234, hex_dec_in 1, sign_in 1 -> load_ready 0 in cycles 6-15; data 16'h0000 through cycle 15; data 16'h1234, hex_dec 1, sign 1 and load_ready 1 from cycle 16.
REQ-035 Loads 16'hAAAA in cycle 2 and 16'h5555 in cycle 6 -> second ignored (ready 0); data 16'hAAAA from cycle 16; data not 16'h5555 at any point.
REQ-036 Load 16'h00FF in cycle 15 (frame_done, pending 0) -> data 16'h0000 in cycle 16; data 16'h00FF from cycle 32; load_ready 0 in cycles 16-31.
REQ-037 Load 16'hBEEF in cycle 3, reset high in cycle 9 -> cycle after reset release: data 16'h0000, load_ready 1, digit_sel 0, prescaler 0; 16'hBEEF never displayed.
REQ-038 REFRESH_DIV = 2 -> digit_tick every second cycle, frame_done every 8th cycle, load latency per REQ-027.

Source files
------------

// File: rtl/sseg_scan.sv
// Seven-segment scan timing and display value handoff.
// A free-running prescaler divides clk into digit slots; four slots make a frame.
// New display values are taken through a one-deep valid/ready shadow and only
// reach the driver-facing outputs on a frame boundary, so a frame never tears.
module sseg_scan #(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] data_in,
    input  logic        hex_dec_in,
    input  logic        sign_in,
    input  logic        load_valid,
    output logic        load_ready,
    output logic [15:0] data,
    output logic        hex_dec,
    output logic        sign,
    output logic [1:0]  digit_sel,
    output logic        digit_tick,
    output logic        frame_done
);

    // Guard keeps the width legal even if someone instantiates an illegal divider.
    localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);

    logic [PW-1:0] r_presc;
    logic [1:0]    r_digit_sel;
    logic [17:0]   r_shadow;
    logic          r_pending;
    logic [15:0]   r_data;
    logic          r_hex_dec;
    logic          r_sign;

    logic          w_tick;
    logic          w_frame_done;
    logic          w_accept;
    logic          w_apply;

    // Slot/frame decode and handshake qualification from registered state.
    always_comb begin
        w_tick       = (r_presc == PRESC_MAX);
        w_frame_done = w_tick && (r_digit_sel == 2'd3);
        w_accept     = load_valid && !r_pending;
        // Pending is sampled at the start of the frame_done cycle, so an offer
        // accepted in that same cycle waits for the following frame.
        w_apply      = w_frame_done && r_pending;
    end

    // Prescaler: counts 0..REFRESH_DIV-1 and wraps, independent of handshakes.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    // Digit index advances at the end of every slot, wrapping 3 -> 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_digit_sel <= 2'd0;
        end else if (w_tick) begin
            r_digit_sel <= r_digit_sel + 2'd1;
        end
    end

    // One-deep shadow: capture an accepted offer, release it at a frame boundary.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shadow  <= '0;
            r_pending <= 1'b0;
        end else if (w_apply) begin
            r_pending <= 1'b0;
        end else if (w_accept) begin
            r_shadow  <= {data_in, hex_dec_in, sign_in};
            r_pending <= 1'b1;
        end
    end

    // Driver-facing display value changes only on a frame boundary with a pending value.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data    <= 16'h0000;
            r_hex_dec <= 1'b0;
            r_sign    <= 1'b0;
        end else if (w_apply) begin
            r_data    <= r_shadow[17:2];
            r_hex_dec <= r_shadow[1];
            r_sign    <= r_shadow[0];
        end
    end

    // Output drive.
    always_comb begin
        load_ready = !r_pending;
        data       = r_data;
        hex_dec    = r_hex_dec;
        sign       = r_sign;
        digit_sel  = r_digit_sel;
        digit_tick = w_tick;
        frame_done = w_frame_done;
    end

endmodule

// File: tb/tb_sseg_scan.sv
// Bench for sseg_scan: one DUT at REFRESH_DIV=4, one at REFRESH_DIV=2.
// Display updates are predicted into a scoreboard queue when an offer is
// driven and popped when the predicted frame boundary is reached.
module tb_sseg_scan;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] data_in;
    logic        hex_dec_in, sign_in, load_valid;
    logic        load_ready, hex_dec, sign, digit_tick, frame_done;
    logic [15:0] data;
    logic [1:0]  digit_sel;

    logic [15:0] data_in2;
    logic        hex_dec_in2, sign_in2, load_valid2;
    logic        load_ready2, hex_dec2, sign2, digit_tick2, frame_done2;
    logic [15:0] data2;
    logic [1:0]  digit_sel2;

    typedef struct {
        int          due;
        logic [17:0] val;
    } exp_t;

    exp_t        sb[$];
    logic [17:0] cur;
    int          errors = 0;
    int          checks = 0;
    int          cyc;

    always #5 clk = ~clk;

    sseg_scan #(.REFRESH_DIV(4)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .hex_dec_in (hex_dec_in),
        .sign_in    (sign_in),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .data       (data),
        .hex_dec    (hex_dec),
        .sign       (sign),
        .digit_sel  (digit_sel),
        .digit_tick (digit_tick),
        .frame_done (frame_done)
    );

    sseg_scan #(.REFRESH_DIV(2)) u_dut2 (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in2),
        .hex_dec_in (hex_dec_in2),
        .sign_in    (sign_in2),
        .load_valid (load_valid2),
        .load_ready (load_ready2),
        .data       (data2),
        .hex_dec    (hex_dec2),
        .sign       (sign2),
        .digit_sel  (digit_sel2),
        .digit_tick (digit_tick2),
        .frame_done (frame_done2)
    );

    // First cycle after the boundary that follows acceptance in cycle c.
    function automatic int due_cycle(input int c, input int frame);
        return ((c + 1) / frame + 1) * frame;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic apply_reset();
        reset       = 1'b1;
        load_valid  = 1'b0;
        load_valid2 = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc   = 0;
        sb.delete();
        cur   = '0;
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        load_valid = 1'b1;
        data_in    = 16'hDEAD;
        hex_dec_in = 1'b1;
        sign_in    = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        checks++;
        if (load_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", load_ready);
        if (load_ready !== 1'b1) errors++;
        checks++;
        if ({digit_tick, frame_done} !== 2'b00) begin
            $display("FAIL reset_ticks: got %b want 00", {digit_tick, frame_done});
            errors++;
        end
        checks++;
        if ({data, hex_dec, sign, digit_sel} !== 20'h0) begin
            $display("FAIL reset_display: got %h want 00000", {data, hex_dec, sign, digit_sel});
            errors++;
        end
        load_valid = 1'b0;
        reset      = 1'b0;
        cyc        = 0;
        sb.delete();
        cur        = '0;
        // Offer present during reset must not have been taken.
        checks++;
        if (load_ready !== 1'b1 || data !== 16'h0000) begin
            $display("FAIL reset_offer_dropped: ready=%b data=%h want 1/0000", load_ready, data);
            errors++;
        end
    endtask

    task automatic test_free_run();
        apply_reset();
        for (int c = 0; c <= 16; c++) begin
            checks++;
            if (digit_tick !== (c % 4 == 3)) begin
                $display("FAIL free_tick c=%0d: got %b want %b", c, digit_tick, (c % 4 == 3));
                errors++;
            end
            checks++;
            if (frame_done !== (c == 15)) begin
                $display("FAIL free_frame c=%0d: got %b want %b", c, frame_done, (c == 15));
                errors++;
            end
            checks++;
            if (digit_sel !== 2'((c / 4) % 4)) begin
                $display("FAIL free_sel c=%0d: got %0d want %0d", c, digit_sel, (c / 4) % 4);
                errors++;
            end
            checks++;
            if (data !== 16'h0000) begin
                $display("FAIL free_data c=%0d: got %h want 0000", c, data);
                errors++;
            end
            step();
        end
    endtask

    task automatic test_single_load();
        exp_t e;
        apply_reset();
        for (int c = 0; c <= 20; c++) begin
            if (sb.size() > 0 && sb[0].due == c) begin
                e   = sb.pop_front();
                cur = e.val;
            end
            checks++;
            if ({data, hex_dec, sign} !== cur) begin
                $display("FAIL load_disp c=%0d: got %h want %h", c, {data, hex_dec, sign}, cur);
                errors++;
            end
            checks++;
            if (load_ready !== (sb.size() == 0)) begin
                $display("FAIL load_ready c=%0d: got %b want %b", c, load_ready, sb.size() == 0);
                errors++;
            end
            load_valid = (c == 5);
            data_in    = 16'h1234;
            hex_dec_in = 1'b1;
            sign_in    = 1'b1;
            if (load_valid && sb.size() == 0) sb.push_back('{due_cycle(c, 16), 18'h048D3});
            step();
        end
        load_valid = 1'b0;
    endtask

    task automatic test_ignored_offer();
        exp_t e;
        apply_reset();
        for (int c = 0; c <= 40; c++) begin
            if (sb.size() > 0 && sb[0].due == c) begin
                e   = sb.pop_front();
                cur = e.val;
            end
            checks++;
            if ({data, hex_dec, sign} !== cur) begin
                $display("FAIL ign_disp c=%0d: got %h want %h", c, {data, hex_dec, sign}, cur);
                errors++;
            end
            checks++;
            if (load_ready !== (sb.size() == 0)) begin
                $display("FAIL ign_ready c=%0d: got %b want %b", c, load_ready, sb.size() == 0);
                errors++;
            end
            load_valid = (c == 2) || (c == 6);
            data_in    = (c == 2) ? 16'hAAAA : 16'h5555;
            hex_dec_in = 1'b0;
            sign_in    = (c == 6);
            if (load_valid && sb.size() == 0) sb.push_back('{due_cycle(c, 16), {data_in, 2'b00}});
            step();
        end
        load_valid = 1'b0;
    endtask

    // Offer in a frame_done cycle, then another as soon as ready returns.
    task automatic test_back_to_back();
        exp_t e;
        apply_reset();
        for (int c = 0; c <= 50; c++) begin
            if (sb.size() > 0 && sb[0].due == c) begin
                e   = sb.pop_front();
                cur = e.val;
            end
            checks++;
            if ({data, hex_dec, sign} !== cur) begin
                $display("FAIL b2b_disp c=%0d: got %h want %h", c, {data, hex_dec, sign}, cur);
                errors++;
            end
            checks++;
            if (load_ready !== (sb.size() == 0)) begin
                $display("FAIL b2b_ready c=%0d: got %b want %b", c, load_ready, sb.size() == 0);
                errors++;
            end
            load_valid = (c == 15) || (c == 32);
            data_in    = (c == 15) ? 16'h00FF : 16'hC3A5;
            hex_dec_in = (c == 32);
            sign_in    = 1'b0;
            if (load_valid && sb.size() == 0) begin
                sb.push_back('{due_cycle(c, 16), {data_in, hex_dec_in, sign_in}});
            end
            step();
        end
        load_valid = 1'b0;
    endtask

    task automatic test_reset_discard();
        apply_reset();
        for (int c = 0; c <= 9; c++) begin
            load_valid = (c == 3);
            data_in    = 16'hBEEF;
            hex_dec_in = 1'b1;
            sign_in    = 1'b0;
            if (c == 9) reset = 1'b1;
            step();
        end
        load_valid = 1'b0;
        reset      = 1'b0;
        cyc        = 0;
        checks++;
        if ({data, hex_dec, sign} !== 18'h0 || load_ready !== 1'b1 || digit_sel !== 2'd0) begin
            $display("FAIL rst_mid_state: data=%h ready=%b sel=%0d want 0000/1/0",
                     data, load_ready, digit_sel);
            errors++;
        end
        for (int c = 0; c <= 40; c++) begin
            checks++;
            if (digit_tick !== (c % 4 == 3)) begin
                $display("FAIL rst_mid_tick c=%0d: got %b want %b", c, digit_tick, (c % 4 == 3));
                errors++;
            end
            checks++;
            if (data !== 16'h0000) begin
                $display("FAIL rst_mid_data c=%0d: got %h want 0000", c, data);
                errors++;
            end
            step();
        end
    endtask

    task automatic test_div2();
        exp_t e;
        apply_reset();
        for (int c = 0; c <= 30; c++) begin
            if (sb.size() > 0 && sb[0].due == c) begin
                e   = sb.pop_front();
                cur = e.val;
            end
            checks++;
            if (digit_tick2 !== (c % 2 == 1) || frame_done2 !== (c % 8 == 7)) begin
                $display("FAIL div2_ticks c=%0d: got %b%b want %b%b", c, digit_tick2,
                         frame_done2, (c % 2 == 1), (c % 8 == 7));
                errors++;
            end
            checks++;
            if (digit_sel2 !== 2'((c / 2) % 4)) begin
                $display("FAIL div2_sel c=%0d: got %0d want %0d", c, digit_sel2, (c / 2) % 4);
                errors++;
            end
            checks++;
            if ({data2, hex_dec2, sign2} !== cur) begin
                $display("FAIL div2_disp c=%0d: got %h want %h", c, {data2, hex_dec2, sign2}, cur);
                errors++;
            end
            checks++;
            if (load_ready2 !== (sb.size() == 0)) begin
                $display("FAIL div2_ready c=%0d: got %b want %b", c, load_ready2, sb.size() == 0);
                errors++;
            end
            load_valid2 = (c == 1) || (c == 4) || (c == 15);
            data_in2    = (c == 15) ? 16'h2468 : 16'h1357;
            hex_dec_in2 = (c != 15);
            sign_in2    = 1'b1;
            if (load_valid2 && sb.size() == 0) begin
                sb.push_back('{due_cycle(c, 8), {data_in2, hex_dec_in2, sign_in2}});
            end
            step();
        end
        load_valid2 = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        load_valid  = 1'b0;
        data_in     = '0;
        hex_dec_in  = 1'b0;
        sign_in     = 1'b0;
        load_valid2 = 1'b0;
        data_in2    = '0;
        hex_dec_in2 = 1'b0;
        sign_in2    = 1'b0;
        cyc         = 0;
        cur         = '0;
        test_reset();
        test_free_run();
        test_single_load();
        test_ignored_offer();
        test_back_to_back();
        test_reset_discard();
        test_div2();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
